// File: rtl/cgra_exec_ctrl.sv
// ---------------------------------------------------------------------------
// cgra_exec_ctrl
//
// Execution sequencer for the 10x10 torus PE array. Software raises
// Computation_Start; the block loads the kernel configuration, steps a global
// instruction address through Inst_Num instructions for Iter_Num iterations,
// holds a drain window of Drain_Num cycles so the last stores reach the BRAM
// interface, then raises Computation_Done until software drops Start.
//
// Handshake (four-phase, level based):
//   Start 0->1 in IDLE launches a kernel. Done rises when the kernel is
//   complete and stays high while Start is high. Start sampled low in DONE
//   returns to IDLE and Done falls. Start falling before DONE is ignored, so
//   Done is then high for exactly one cycle.
//
// Ports:
//   Clk, Resetn          clock, asynchronous active-low reset
//   Computation_Start    software start level
//   Inst_Num             instructions per iteration (clamped to 2^IADDR_WIDTH)
//   Iter_Num             iteration count
//   Drain_Num            drain cycles after the last instruction
//   Inst_Addr            global instruction address to all PEs
//   Inst_Rd_En           instruction fetch enable (RUN only)
//   Iter_Cnt             current iteration index
//   PE_Array_Busy        high during RUN and DRAIN
//   Cycle_Cnt            RUN+DRAIN cycle count of the last kernel
//   Computation_Done     handshake completion flag
//   dbg_state            current FSM state for observation
//
// All outputs are registered: they are loaded from the next-state decision,
// so each output already reflects the state being entered.
// ---------------------------------------------------------------------------
module cgra_exec_ctrl #(
    parameter int IADDR_WIDTH = 10,
    parameter int ITER_WIDTH  = 16,
    parameter int DRAIN_WIDTH = 6,
    parameter int CYC_WIDTH   = 32
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Computation_Start,
    input  logic [IADDR_WIDTH:0]   Inst_Num,
    input  logic [ITER_WIDTH-1:0]  Iter_Num,
    input  logic [DRAIN_WIDTH-1:0] Drain_Num,
    output logic [IADDR_WIDTH-1:0] Inst_Addr,
    output logic                   Inst_Rd_En,
    output logic [ITER_WIDTH-1:0]  Iter_Cnt,
    output logic                   PE_Array_Busy,
    output logic [CYC_WIDTH-1:0]   Cycle_Cnt,
    output logic                   Computation_Done,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [IADDR_WIDTH:0] INST_MAX = {1'b1, {IADDR_WIDTH{1'b0}}};

    state_t                 state;
    state_t                 state_nxt;

    logic [IADDR_WIDTH:0]   inst_num_q;
    logic [ITER_WIDTH-1:0]  iter_num_q;
    logic [DRAIN_WIDTH-1:0] drain_num_q;
    logic [DRAIN_WIDTH-1:0] drain_cnt;

    logic [IADDR_WIDTH:0]   inst_clamped;
    logic [IADDR_WIDTH:0]   inst_last;
    logic                   addr_wrap;
    logic                   iter_last;
    logic                   drain_end;

    assign dbg_state = state;

    // Program length can legally equal 2^IADDR_WIDTH, hence the extra bit.
    assign inst_clamped = (Inst_Num > INST_MAX) ? INST_MAX : Inst_Num;
    assign inst_last    = inst_num_q - (IADDR_WIDTH + 1)'(1);
    assign addr_wrap    = ({1'b0, Inst_Addr} == inst_last);
    assign iter_last    = (Iter_Cnt == iter_num_q - ITER_WIDTH'(1));
    assign drain_end    = (drain_cnt == drain_num_q - DRAIN_WIDTH'(1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Computation_Start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                // Zero-work kernels skip RUN and the drain window entirely.
                if ((inst_clamped == '0) || (Iter_Num == '0)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (addr_wrap && iter_last) begin
                    state_nxt = (drain_num_q == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!Computation_Start) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registered outputs and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Inst_Addr        <= '0;
            Inst_Rd_En       <= 1'b0;
            Iter_Cnt         <= '0;
            PE_Array_Busy    <= 1'b0;
            Cycle_Cnt        <= '0;
            Computation_Done <= 1'b0;
            inst_num_q       <= '0;
            iter_num_q       <= '0;
            drain_num_q      <= '0;
            drain_cnt        <= '0;
        end else begin
            Inst_Rd_En       <= (state_nxt == S_RUN);
            PE_Array_Busy    <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
            Computation_Done <= (state_nxt == S_DONE);

            case (state)
                S_IDLE: begin
                    // Clear on entry so the LOAD cycle already reads zero.
                    if (Computation_Start) begin
                        Inst_Addr <= '0;
                        Iter_Cnt  <= '0;
                        Cycle_Cnt <= '0;
                    end
                end
                S_LOAD: begin
                    inst_num_q  <= inst_clamped;
                    iter_num_q  <= Iter_Num;
                    drain_num_q <= Drain_Num;
                    drain_cnt   <= '0;
                    Inst_Addr   <= '0;
                end
                S_RUN: begin
                    Cycle_Cnt <= Cycle_Cnt + CYC_WIDTH'(1);
                    if (addr_wrap) begin
                        Inst_Addr <= '0;
                        Iter_Cnt  <= Iter_Cnt + ITER_WIDTH'(1);
                    end else begin
                        Inst_Addr <= Inst_Addr + IADDR_WIDTH'(1);
                    end
                end
                S_DRAIN: begin
                    Cycle_Cnt <= Cycle_Cnt + CYC_WIDTH'(1);
                    drain_cnt <= drain_cnt + DRAIN_WIDTH'(1);
                    Inst_Addr <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cgra_exec_ctrl
//
// Bench for the execution sequencer. A behavioural model tracks how many
// cycles have passed since Start was accepted and derives every output from
// that offset and the loaded configuration. One compare process checks all
// outputs against the model on every negative clock edge; directed tests add
// hand-computed expectations at specific cycles.
// ---------------------------------------------------------------------------
module tb_cgra_exec_ctrl;

  localparam int IW = 10;
  localparam int TW = 16;
  localparam int DW = 6;
  localparam int CW = 32;
  localparam int INST_CAP = 1 << IW;

  // ---------------------------------------------------------------- clock/reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW:0]   inst_num = '0;
  logic [TW-1:0] iter_num = '0;
  logic [DW-1:0] drain_num = '0;

  logic [IW-1:0] inst_addr;
  logic          inst_rd_en;
  logic [TW-1:0] iter_cnt;
  logic          busy;
  logic [CW-1:0] cycle_cnt;
  logic          done;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  cgra_exec_ctrl #(
    .IADDR_WIDTH(IW),
    .ITER_WIDTH (TW),
    .DRAIN_WIDTH(DW),
    .CYC_WIDTH  (CW)
  ) dut (
    .Clk              (clk),
    .Resetn           (rst_n),
    .Computation_Start(start),
    .Inst_Num         (inst_num),
    .Iter_Num         (iter_num),
    .Drain_Num        (drain_num),
    .Inst_Addr        (inst_addr),
    .Inst_Rd_En       (inst_rd_en),
    .Iter_Cnt         (iter_cnt),
    .PE_Array_Busy    (busy),
    .Cycle_Cnt        (cycle_cnt),
    .Computation_Done (done),
    .dbg_state        (dbg_state)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_err    = 0;
  int cyc_no   = 0;
  int base     = 0;
  bit chk_en   = 1'b1;

  always @(posedge clk) cyc_no <= cyc_no + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, rel %0d)", name, act, exp, cyc_no, cyc_no - base);
    end
  endtask

  // ---------------------------------------------------------------- model
  // m_p is the number of edges since Start was accepted: p=1 is the load
  // cycle, p>=2 runs the kernel, and the kernel is complete at p = 2 + total.
  bit      m_active = 1'b0;
  bit      m_done   = 1'b0;
  int      m_p = 0;
  int      m_n = 0;
  int      m_i = 0;
  int      m_d = 0;
  int      m_iter_hold = 0;
  longint  m_cyc_hold  = 0;

  function automatic int clampn(input int v);
    return (v > INST_CAP) ? INST_CAP : v;
  endfunction

  function automatic int total_of(input int n, input int i, input int d);
    return (n * i == 0) ? 0 : n * i + d;
  endfunction

  function automatic int cur_total();
    if (m_p == 1) return total_of(clampn(int'(inst_num)), int'(iter_num), int'(drain_num));
    return total_of(m_n, m_i, m_d);
  endfunction

  function automatic int cur_iter();
    if (m_p == 1) return (clampn(int'(inst_num)) * int'(iter_num) == 0) ? 0 : int'(iter_num);
    return (m_n * m_i == 0) ? 0 : m_i;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active    <= 1'b0;
      m_done      <= 1'b0;
      m_p         <= 0;
      m_iter_hold <= 0;
      m_cyc_hold  <= 0;
    end else if (!m_active && !m_done) begin
      if (start) begin
        m_active <= 1'b1;
        m_p      <= 1;
      end
    end else if (m_active) begin
      if (m_p == 1) begin
        m_n <= clampn(int'(inst_num));
        m_i <= int'(iter_num);
        m_d <= int'(drain_num);
      end
      if (m_p + 1 == 2 + cur_total()) begin
        m_active    <= 1'b0;
        m_done      <= 1'b1;
        m_iter_hold <= cur_iter();
        m_cyc_hold  <= longint'(cur_total());
      end
      m_p <= m_p + 1;
    end else if (!start) begin
      m_done <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- compare
  task automatic compare_cycle();
    int     e_addr = 0;
    int     e_rd   = 0;
    int     e_iter = 0;
    int     e_busy = 0;
    int     e_done = 0;
    longint e_cyc  = 0;
    int     r;
    if (m_active) begin
      if (m_p >= 2) begin
        r = m_p - 2;
        e_busy = 1;
        e_cyc  = longint'(r);
        if (r < m_n * m_i) begin
          e_addr = r % m_n;
          e_iter = r / m_n;
          e_rd   = 1;
        end else begin
          e_iter = m_i;
        end
      end
    end else begin
      e_iter = m_iter_hold;
      e_cyc  = m_cyc_hold;
      e_done = m_done ? 1 : 0;
    end
    check("m_inst_addr", 64'(inst_addr),  64'(e_addr));
    check("m_rd_en",     64'(inst_rd_en), 64'(e_rd));
    check("m_iter_cnt",  64'(iter_cnt),   64'(e_iter));
    check("m_busy",      64'(busy),       64'(e_busy));
    check("m_cycle_cnt", 64'(cycle_cnt),  64'(e_cyc));
    check("m_done",      64'(done),       64'(e_done));
  endtask

  always @(negedge clk) if (chk_en) compare_cycle();

  // ---------------------------------------------------------------- drivers
  // Configuration only matters in the load cycle; elsewhere it is scrambled.
  int cfg_n = 0;
  int cfg_i = 0;
  int cfg_d = 0;

  always @(negedge clk) begin
    if (m_active && m_p == 1) begin
      inst_num  = (IW + 1)'(cfg_n);
      iter_num  = TW'(cfg_i);
      drain_num = DW'(cfg_d);
    end else begin
      inst_num  = (IW + 1)'($urandom);
      iter_num  = TW'($urandom);
      drain_num = DW'($urandom);
    end
  end

  // Called just after a negative edge: raises Start in the current cycle,
  // which becomes relative cycle 0.
  task automatic launch(input int n, input int i, input int d);
    cfg_n = n;
    cfg_i = i;
    cfg_d = d;
    start = 1'b1;
    base  = cyc_no;
  endtask

  task automatic at(input int c);
    while (cyc_no - base < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 5000 && (m_active || m_done); t++) @(negedge clk);
    n_checks++;
    if (m_active || m_done) begin
      n_err++;
      $display("FAIL idle_timeout: kernel still active after 5000 cycles");
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    repeat (2) @(negedge clk);
    check("rst_addr",  64'(inst_addr),  64'd0);
    check("rst_rd",    64'(inst_rd_en), 64'd0);
    check("rst_iter",  64'(iter_cnt),   64'd0);
    check("rst_busy",  64'(busy),       64'd0);
    check("rst_cyc",   64'(cycle_cnt),  64'd0);
    check("rst_done",  64'(done),       64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic kernel: 3 instructions x 2 iterations, 2 drain cycles.
    launch(3, 2, 2);
    at(2);  check("basic_addr_c2", 64'(inst_addr), 64'd0);
            check("basic_rd_c2",   64'(inst_rd_en), 64'd1);
    at(4);  check("basic_addr_c4", 64'(inst_addr), 64'd2);
            check("basic_iter_c4", 64'(iter_cnt),  64'd0);
    at(5);  check("basic_addr_c5", 64'(inst_addr), 64'd0);
            check("basic_iter_c5", 64'(iter_cnt),  64'd1);
    at(7);  check("basic_addr_c7", 64'(inst_addr), 64'd2);
    at(9);  check("basic_busy_c9", 64'(busy),      64'd1);
            check("basic_done_c9", 64'(done),      64'd0);
    at(10); check("basic_done_c10", 64'(done),     64'd1);
            check("basic_busy_c10", 64'(busy),     64'd0);
            check("basic_cyc_c10",  64'(cycle_cnt), 64'd8);
            check("basic_iter_c10", 64'(iter_cnt),  64'd2);
    at(14); check("basic_done_c14", 64'(done),     64'd1);
            start = 1'b0;
    at(15); check("basic_done_c15", 64'(done),     64'd0);
            check("b2b_hold_cyc",   64'(cycle_cnt), 64'd8);

    // Back-to-back: new config, counters cleared in the load cycle.
    launch(5, 1, 1);
    at(1);  check("b2b_load_cyc",  64'(cycle_cnt), 64'd0);
            check("b2b_load_iter", 64'(iter_cnt),  64'd0);
    at(6);  check("b2b_addr_c6",   64'(inst_addr), 64'd4);
    at(7);  check("b2b_drain_rd",  64'(inst_rd_en), 64'd0);
            check("b2b_drain_busy", 64'(busy),     64'd1);
    at(8);  check("b2b_done",      64'(done),      64'd1);
            check("b2b_cyc",       64'(cycle_cnt), 64'd6);
            start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Zero work: Iter_Num = 0 with Start held.
    launch(4, 0, 3);
    at(1);  check("zero_done_c1", 64'(done), 64'd0);
    at(2);  check("zero_done_c2", 64'(done), 64'd1);
            check("zero_busy_c2", 64'(busy), 64'd0);
            check("zero_cyc_c2",  64'(cycle_cnt), 64'd0);
    at(3);  check("zero_done_c3", 64'(done), 64'd1);
            start = 1'b0;
    at(4);  check("zero_done_c4", 64'(done), 64'd0);
    @(negedge clk);

    // Early Start release: Start high only in cycle 0.
    launch(4, 1, 0);
    at(1);  start = 1'b0;
    at(2);  check("early_rd_c2",   64'(inst_rd_en), 64'd1);
    at(5);  check("early_addr_c5", 64'(inst_addr),  64'd3);
            check("early_busy_c5", 64'(busy),       64'd1);
    at(6);  check("early_done_c6", 64'(done),       64'd1);
            check("early_cyc_c6",  64'(cycle_cnt),  64'd4);
    at(7);  check("early_done_c7", 64'(done),       64'd0);
    @(negedge clk);

    // Clamp: 1500 instructions limited to 1024.
    launch(1500, 1, 0);
    at(1025); check("clamp_addr_last", 64'(inst_addr), 64'd1023);
    at(1026); check("clamp_done",      64'(done),      64'd1);
              check("clamp_cyc",       64'(cycle_cnt), 64'd1024);
              check("clamp_addr_wrap", 64'(inst_addr), 64'd0);
              start = 1'b0;
    wait_idle();
    @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    launch(8, 4, 0);
    at(10);
    #2 rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("arst_addr", 64'(inst_addr),  64'd0);
    check("arst_rd",   64'(inst_rd_en), 64'd0);
    check("arst_iter", 64'(iter_cnt),   64'd0);
    check("arst_busy", 64'(busy),       64'd0);
    check("arst_cyc",  64'(cycle_cnt),  64'd0);
    check("arst_done", 64'(done),       64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_idle_done",  64'(done),      64'd0);
    check("arst_idle_state", 64'(dbg_state), 64'd0);

    // Randomized kernels with random Start hold times and idle gaps.
    for (int k = 0; k < 30; k++) begin
      int n;
      int i;
      int d;
      int hold;
      n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 7));
      i = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 3));
      launch(n, i, d);
      hold = int'($urandom_range(1, n * i + d + 5));
      repeat (hold) @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
